core_controller: RTL

Multi-cycle sequencer for the TiniSOC core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the per-stage enables, including `enable_execute` into the ALU. It selects the next-PC source from opcode and `alu_zero`, and latches sticky status (overflow, illegal opcode, bus timeout). It sits between the instruction register/decoder and the ALU, register file and memory ports.

---
 rtl/core_controller_pkg.sv | 47 ++++
 rtl/core_controller_instr_class.sv | 71 +++++++
 rtl/core_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/core_controller_pkg.sv
// Shared definitions for the TiniSOC core controller.
// Holds the opcode / sub-opcode constants, the controller state encoding
// and the next-PC select codes used by core_controller and instr_class.
package core_controller_pkg;

    // Primary opcodes
    localparam logic [5:0] TY_BASE = 6'h00;
    localparam logic [5:0] ADDI    = 6'h01;
    localparam logic [5:0] ORI     = 6'h02;
    localparam logic [5:0] XORI    = 6'h03;
    localparam logic [5:0] MOVI    = 6'h04;
    localparam logic [5:0] LWI     = 6'h05;
    localparam logic [5:0] SWI     = 6'h06;
    localparam logic [5:0] TY_LS   = 6'h07;
    localparam logic [5:0] TY_B    = 6'h08;
    localparam logic [5:0] JJ      = 6'h09;

    // TY_BASE sub-opcodes
    localparam logic [4:0] ADD   = 5'h00;
    localparam logic [4:0] SUB   = 5'h01;
    localparam logic [4:0] AND   = 5'h02;
    localparam logic [4:0] OR    = 5'h03;
    localparam logic [4:0] XOR   = 5'h04;
    localparam logic [4:0] SRLI  = 5'h05;
    localparam logic [4:0] SLLI  = 5'h06;
    localparam logic [4:0] ROTRI = 5'h07;

    // TY_LS sub-opcodes
    localparam logic [7:0] LW = 8'h02;
    localparam logic [7:0] SW = 8'h0A;

    // Next-PC select
    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

endpackage

// File: rtl/core_controller_instr_class.sv
// instr_class: combinational instruction classifier.
// Inputs : opcode, sub_op_base, sub_op_ls
// Outputs: is_alu, is_arith (overflow-relevant), is_load, is_store,
//          is_branch, is_jump, is_illegal (unknown opcode or sub-op)
module instr_class
    import core_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] sub_op_base,
    input  logic [7:0] sub_op_ls,
    output logic       is_alu,
    output logic       is_arith,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_illegal
);

    always_comb begin
        is_alu     = 1'b0;
        is_arith   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            TY_BASE: begin
                case (sub_op_base)
                    ADD, SUB: begin
                        is_alu   = 1'b1;
                        is_arith = 1'b1;
                    end
                    AND, OR, XOR, SRLI, SLLI, ROTRI: is_alu = 1'b1;
                    default: is_illegal = 1'b1;
                endcase
            end
            ADDI: begin
                is_alu   = 1'b1;
                is_arith = 1'b1;
            end
            ORI, XORI, MOVI: is_alu = 1'b1;
            LWI: begin
                is_load  = 1'b1;
                is_arith = 1'b1;
            end
            SWI: begin
                is_store = 1'b1;
                is_arith = 1'b1;
            end
            TY_LS: begin
                case (sub_op_ls)
                    LW: begin
                        is_load  = 1'b1;
                        is_arith = 1'b1;
                    end
                    SW: begin
                        is_store = 1'b1;
                        is_arith = 1'b1;
                    end
                    default: is_illegal = 1'b1;
                endcase
            end
            TY_B:    is_branch  = 1'b1;
            JJ:      is_jump    = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_controller.sv
// core_controller: multi-cycle sequencer for the TiniSOC core.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Inputs : clock, reset (sync, active-high), run, opcode, sub_op_base,
//          sub_op_ls, branch_ne, alu_zero, alu_overflow, mem_ready
// Outputs: enable_{fetch,decode,execute,mem_read,mem_write,writeback},
//          pc_write/pc_src (next-PC update), retired (instruction count),
//          overflow_flag/illegal/bus_error (sticky), halted
module core_controller
    import core_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [4:0]  sub_op_base,
    input  logic [7:0]  sub_op_ls,
    input  logic        branch_ne,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        mem_ready,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_mem_read,
    output logic        enable_mem_write,
    output logic        enable_writeback,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [31:0] retired,
    output logic        overflow_flag,
    output logic        illegal,
    output logic        bus_error,
    output logic        halted
);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       waiting;
    logic       wait_expired;
    logic       taken;

    logic is_alu, is_arith, is_load, is_store, is_branch, is_jump, is_illegal;

    instr_class u_instr_class (
        .opcode      (opcode),
        .sub_op_base (sub_op_base),
        .sub_op_ls   (sub_op_ls),
        .is_alu      (is_alu),
        .is_arith    (is_arith),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .is_illegal  (is_illegal)
    );

    assign waiting      = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
    // Expiry only fires while still waiting, so mem_ready in the last cycle wins.
    assign wait_expired = waiting && (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign taken        = alu_zero ^ branch_ne;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (run) next_state = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)         next_state = ST_DECODE;
                else if (wait_expired) next_state = ST_HALT;
            end
            ST_DECODE: begin
                if (is_illegal)   next_state = ST_HALT;
                else if (is_jump) next_state = ST_FETCH;
                else              next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_branch)                 next_state = ST_FETCH;
                else if (is_load || is_store)  next_state = ST_MEM;
                else if (is_alu)               next_state = ST_WRITEBACK;
                else                           next_state = ST_HALT;
            end
            ST_MEM: begin
                if (mem_ready)         next_state = is_load ? ST_WRITEBACK : ST_FETCH;
                else if (wait_expired) next_state = ST_HALT;
            end
            ST_WRITEBACK: next_state = ST_FETCH;
            ST_HALT:      next_state = ST_HALT;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Outputs: stage enables from state, PC update from state plus inputs
    always_comb begin
        enable_fetch     = (state == ST_FETCH);
        enable_decode    = (state == ST_DECODE);
        enable_execute   = (state == ST_EXECUTE);
        enable_mem_read  = (state == ST_MEM) && is_load;
        enable_mem_write = (state == ST_MEM) && is_store;
        enable_writeback = (state == ST_WRITEBACK);
        halted           = (state == ST_HALT);

        pc_src = PC_SRC_SEQ;
        if ((state == ST_DECODE) && is_jump && !is_illegal) pc_src = PC_SRC_JUMP;
        else if ((state == ST_EXECUTE) && is_branch && taken) pc_src = PC_SRC_BRANCH;

        // Suppressed under reset so an aborted instruction never retires.
        pc_write = !reset && (((state == ST_DECODE) && is_jump && !is_illegal) ||
                              ((state == ST_EXECUTE) && is_branch) ||
                              ((state == ST_MEM) && is_store && mem_ready) ||
                              (state == ST_WRITEBACK));
    end

    // Wait counter, retire counter and sticky status
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt      <= '0;
            retired       <= '0;
            overflow_flag <= 1'b0;
            illegal       <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            // FETCH/MEM never self-loop except while waiting, so any state
            // change is an entry that restarts the count.
            if (next_state != state) wait_cnt <= '0;
            else if (waiting)        wait_cnt <= wait_cnt + 8'd1;

            if (pc_write) retired <= retired + 32'd1;
            if ((state == ST_EXECUTE) && is_arith && alu_overflow) overflow_flag <= 1'b1;
            if ((state == ST_DECODE) && is_illegal) illegal <= 1'b1;
            if (wait_expired) bus_error <= 1'b1;
        end
    end

endmodule
